// File: rtl/trap_unit.sv
// Purpose: machine-mode trap responder; commits trap CSRs, kills the trapping regwrite, flushes and redirects fetch.
// Latency: kill_w and csr_rdata_w are combinational; flush_all/redirect_* are registered, one cycle after the commit edge.
// Backpressure: none; while flushing, trap requests and CSR accesses are dropped because they belong to flushed instructions.
//
// Ports: clk, start (sync active-low reset), trap_req_w (packed trap request at writeback),
//        csr_valid_w/csr_addr_w/csr_op_w/csr_wdata_w (Zicsr access), csr_rdata_w (old CSR value),
//        kill_w (drop regwrite), flush_all/redirect_valid/redirect_pc (registered fetch control), busy.

package trap_unit_pkg;
    typedef enum logic {
        TRAP_ENTER  = 1'b0,
        TRAP_RETURN = 1'b1
    } trap_mode_e;

    typedef struct packed {
        logic        valid;
        trap_mode_e  mode;
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] tval;
    } trap_req_t;
endpackage

module trap_unit
    import trap_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET      = 32'h0000_0000,
    parameter int unsigned MSTATUS_MIE_BIT  = 3,
    parameter int unsigned MSTATUS_MPIE_BIT = 7
) (
    input  logic        clk,
    input  logic        start,
    input  trap_req_t   trap_req_w,
    input  logic        csr_valid_w,
    input  logic [11:0] csr_addr_w,
    input  logic [2:0]  csr_op_w,
    input  logic [31:0] csr_wdata_w,
    output logic [31:0] csr_rdata_w,
    output logic        kill_w,
    output logic        flush_all,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        trap_take;
    logic        csr_wr_en;
    logic [31:0] csr_new;
    logic [31:0] mstatus_rd;

    // Only MIE and MPIE are implemented in mstatus; every other bit reads zero.
    logic        mie_q, mpie_q;
    logic [31:0] mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;

    // FSM next-state: a trap is only accepted from IDLE.
    always_comb begin
        state_d   = state_q;
        trap_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (trap_req_w.valid) begin
                    trap_take = 1'b1;
                    state_d   = FLUSH;
                end
            end
            FLUSH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign kill_w = trap_take && (trap_req_w.mode == TRAP_ENTER);

    always_comb begin
        mstatus_rd                   = '0;
        mstatus_rd[MSTATUS_MIE_BIT]  = mie_q;
        mstatus_rd[MSTATUS_MPIE_BIT] = mpie_q;
    end

    always_comb begin
        csr_rdata_w = '0;
        case (csr_addr_w)
            CSR_MSTATUS:  csr_rdata_w = mstatus_rd;
            CSR_MTVEC:    csr_rdata_w = mtvec_q;
            CSR_MSCRATCH: csr_rdata_w = mscratch_q;
            CSR_MEPC:     csr_rdata_w = mepc_q;
            CSR_MCAUSE:   csr_rdata_w = mcause_q;
            CSR_MTVAL:    csr_rdata_w = mtval_q;
            default:      csr_rdata_w = '0;
        endcase
    end

    // funct3[1:0]: 01 RW, 10 RS, 11 RC; bit 2 only selects the zimm form upstream.
    always_comb begin
        csr_new = csr_rdata_w;
        case (csr_op_w[1:0])
            2'b01:   csr_new = csr_wdata_w;
            2'b10:   csr_new = csr_rdata_w | csr_wdata_w;
            2'b11:   csr_new = csr_rdata_w & ~csr_wdata_w;
            default: csr_new = csr_rdata_w;
        endcase
    end

    // A trap on the same cycle wins; RS/RC with a zero operand are pure reads.
    assign csr_wr_en = csr_valid_w && (state_q == IDLE) && !trap_req_w.valid
                       && (csr_op_w[1:0] != 2'b00)
                       && !(csr_op_w[1] && (csr_wdata_w == '0));

    always_ff @(posedge clk) begin
        if (!start) begin
            state_q        <= IDLE;
            flush_all      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            mie_q          <= 1'b0;
            mpie_q         <= 1'b0;
            mtvec_q        <= {MTVEC_RESET[31:2], 2'b00};
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mscratch_q     <= '0;
        end else begin
            state_q        <= state_d;
            flush_all      <= trap_take;
            redirect_valid <= trap_take;
            if (trap_take) begin
                if (trap_req_w.mode == TRAP_ENTER) begin
                    // Direct mode only: the low mtvec bits are always zero.
                    redirect_pc <= {mtvec_q[31:2], 2'b00};
                    mepc_q      <= {trap_req_w.pc[31:2], 2'b00};
                    mcause_q    <= trap_req_w.cause;
                    mtval_q     <= trap_req_w.tval;
                    mpie_q      <= mie_q;
                    mie_q       <= 1'b0;
                end else begin
                    redirect_pc <= mepc_q;
                    mie_q       <= mpie_q;
                    mpie_q      <= 1'b1;
                end
            end else if (csr_wr_en) begin
                case (csr_addr_w)
                    CSR_MSTATUS: begin
                        mie_q  <= csr_new[MSTATUS_MIE_BIT];
                        mpie_q <= csr_new[MSTATUS_MPIE_BIT];
                    end
                    CSR_MTVEC:    mtvec_q    <= {csr_new[31:2], 2'b00};
                    CSR_MSCRATCH: mscratch_q <= csr_new;
                    CSR_MEPC:     mepc_q     <= {csr_new[31:2], 2'b00};
                    CSR_MCAUSE:   mcause_q   <= csr_new;
                    CSR_MTVAL:    mtval_q    <= csr_new;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trap_unit.sv
module tb_trap_unit;
    import trap_unit_pkg::*;

    localparam logic [31:0] MTVEC_RST     = 32'h1000_0043;
    localparam logic [31:0] MTVEC_RST_EXP = 32'h1000_0040;

    logic        clk = 1'b0;
    logic        start = 1'b0;
    trap_req_t   trap_req_w;
    logic        csr_valid_w;
    logic [11:0] csr_addr_w;
    logic [2:0]  csr_op_w;
    logic [31:0] csr_wdata_w;
    logic [31:0] csr_rdata_w;
    logic        kill_w;
    logic        flush_all;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    trap_unit #(
        .MTVEC_RESET      (MTVEC_RST),
        .MSTATUS_MIE_BIT  (3),
        .MSTATUS_MPIE_BIT (7)
    ) dut (
        .clk            (clk),
        .start          (start),
        .trap_req_w     (trap_req_w),
        .csr_valid_w    (csr_valid_w),
        .csr_addr_w     (csr_addr_w),
        .csr_op_w       (csr_op_w),
        .csr_wdata_w    (csr_wdata_w),
        .csr_rdata_w    (csr_rdata_w),
        .kill_w         (kill_w),
        .flush_all      (flush_all),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Scoreboard side: every redirect pulse must match the oldest pushed target.
    always @(negedge clk) begin
        if (redirect_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL redirect_unexpected: observed pc=%h expected no redirect", redirect_pc);
            end else begin
                chk("redirect_pc", redirect_pc, exp_q.pop_front());
                chk("flush_with_redirect", {31'd0, flush_all}, 32'd1);
            end
        end
    end

    task automatic clear();
        trap_req_w  = '0;
        csr_valid_w = 1'b0;
        csr_addr_w  = '0;
        csr_op_w    = '0;
        csr_wdata_w = '0;
    endtask

    task automatic idle_cyc();
        @(negedge clk);
        clear();
        #1;
    endtask

    task automatic csr_acc(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d);
        @(negedge clk);
        clear();
        csr_valid_w = 1'b1;
        csr_addr_w  = a;
        csr_op_w    = op;
        csr_wdata_w = d;
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_acc(a, 3'd2, 32'd0);
        chk(tag, csr_rdata_w, exp);
    endtask

    task automatic trap(input trap_mode_e m, input logic [31:0] c, input logic [31:0] p, input logic [31:0] t);
        @(negedge clk);
        clear();
        trap_req_w = '{valid: 1'b1, mode: m, cause: c, pc: p, tval: t};
        #1;
    endtask

    initial begin
        clear();
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;

        // 1: reset state
        rd("rst_mtvec", 12'h305, MTVEC_RST_EXP);
        chk("rst_flush", {31'd0, flush_all}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        rd("rst_mepc", 12'h341, 32'd0);
        rd("rst_mstatus", 12'h300, 32'd0);

        // 2: program mtvec then take a trap
        csr_acc(12'h305, 3'd1, 32'h8000_0103);
        rd("mtvec_aligned", 12'h305, 32'h8000_0100);
        trap(TRAP_ENTER, 32'd2, 32'h0000_0104, 32'h0000_FFFF);
        exp_q.push_back(32'h8000_0100);
        chk("enter_kill", {31'd0, kill_w}, 32'd1);
        idle_cyc();
        chk("flush_pulse", {31'd0, flush_all}, 32'd1);
        chk("busy_flush", {31'd0, busy}, 32'd1);
        idle_cyc();
        chk("flush_end", {31'd0, flush_all}, 32'd0);
        chk("busy_end", {31'd0, busy}, 32'd0);
        rd("t2_mepc", 12'h341, 32'h0000_0104);
        rd("t2_mcause", 12'h342, 32'd2);
        rd("t2_mtval", 12'h343, 32'h0000_FFFF);
        rd("t2_mstatus", 12'h300, 32'd0);

        // 3: set MIE, enter, return
        csr_acc(12'h300, 3'd6, 32'h8);
        rd("mie_set", 12'h300, 32'h8);
        trap(TRAP_ENTER, 32'd11, 32'h0000_0107, 32'd0);
        exp_q.push_back(32'h8000_0100);
        idle_cyc();
        idle_cyc();
        rd("enter_mstatus", 12'h300, 32'h80);
        rd("mepc_masked", 12'h341, 32'h0000_0104);
        trap(TRAP_RETURN, 32'd0, 32'd0, 32'd0);
        exp_q.push_back(32'h0000_0104);
        chk("return_kill", {31'd0, kill_w}, 32'd0);
        idle_cyc();
        idle_cyc();
        rd("return_mstatus", 12'h300, 32'h88);
        rd("return_mcause_kept", 12'h342, 32'd11);

        // CSR op variety and unmapped addresses
        csr_acc(12'h340, 3'd1, 32'h1234_5678);
        rd("mscratch_rw", 12'h340, 32'h1234_5678);
        csr_acc(12'h340, 3'd7, 32'h0000_0078);
        rd("mscratch_rc", 12'h340, 32'h1234_5600);
        csr_acc(12'h7C0, 3'd1, 32'hFFFF_FFFF);
        rd("unmapped", 12'h7C0, 32'd0);
        csr_acc(12'h300, 3'd1, 32'hFFFF_FFFF);
        rd("mstatus_wmask", 12'h300, 32'h88);

        // 4: CSR access colliding with a trap is dropped
        trap(TRAP_ENTER, 32'd7, 32'h0000_0200, 32'h55);
        csr_valid_w = 1'b1;
        csr_addr_w  = 12'h300;
        csr_op_w    = 3'd3;
        csr_wdata_w = 32'h8;
        exp_q.push_back(32'h8000_0100);
        #1;
        chk("collide_kill", {31'd0, kill_w}, 32'd1);
        idle_cyc();
        idle_cyc();
        rd("collide_mstatus", 12'h300, 32'h80);
        rd("collide_mepc", 12'h341, 32'h0000_0200);
        trap(TRAP_ENTER, 32'd8, 32'h0000_0204, 32'd0);
        csr_valid_w = 1'b1;
        csr_addr_w  = 12'h340;
        csr_op_w    = 3'd1;
        csr_wdata_w = 32'hDEAD_BEEF;
        exp_q.push_back(32'h8000_0100);
        idle_cyc();
        idle_cyc();
        rd("collide_mscratch", 12'h340, 32'h1234_5600);

        // 5: requests during FLUSH are ignored; next-cycle trap accepted
        trap(TRAP_ENTER, 32'd3, 32'h0000_0300, 32'd0);
        exp_q.push_back(32'h8000_0100);
        trap(TRAP_ENTER, 32'd4, 32'h0000_0400, 32'd0);
        csr_valid_w = 1'b1;
        csr_addr_w  = 12'h340;
        csr_op_w    = 3'd1;
        csr_wdata_w = 32'h0BAD_0BAD;
        #1;
        chk("flush_kill", {31'd0, kill_w}, 32'd0);
        trap(TRAP_ENTER, 32'd5, 32'h0000_0500, 32'h77);
        exp_q.push_back(32'h8000_0100);
        chk("gap_flush", {31'd0, flush_all}, 32'd0);
        chk("gap_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("b2b_kill", {31'd0, kill_w}, 32'd1);
        idle_cyc();
        idle_cyc();
        rd("b2b_mepc", 12'h341, 32'h0000_0500);
        rd("b2b_mcause", 12'h342, 32'd5);
        rd("b2b_mscratch", 12'h340, 32'h1234_5600);

        // 6: reset during FLUSH
        csr_acc(12'h300, 3'd1, 32'h8);
        trap(TRAP_ENTER, 32'd9, 32'h0000_0600, 32'h99);
        exp_q.push_back(32'h8000_0100);
        idle_cyc();
        start = 1'b0;
        idle_cyc();
        chk("rst2_flush", {31'd0, flush_all}, 32'd0);
        chk("rst2_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst2_redirect_pc", redirect_pc, 32'd0);
        chk("rst2_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        rd("rst2_mstatus", 12'h300, 32'd0);
        rd("rst2_mtvec", 12'h305, MTVEC_RST_EXP);
        rd("rst2_mepc", 12'h341, 32'd0);
        rd("rst2_mcause", 12'h342, 32'd0);
        rd("rst2_mtval", 12'h343, 32'd0);
        rd("rst2_mscratch", 12'h340, 32'd0);
        idle_cyc();
        chk("redirects_consumed", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_unit.md
Name: trap_unit

Overview:
Machine-mode trap responder that consumes the trap_req_t packet at writeback, raised by the decode stage and carried down the pipe. On each request it:
- commits the machine trap CSRs (mstatus, mtvec, mepc, mcause, mtval, mscratch);
- kills the trapping instruction's register write;
- issues a one-cycle pipeline flush plus a PC redirect to fetch.

It also serves Zicsr read/write accesses to those CSRs from writeback.

Parameters:
MTVEC_RESET, 32'h0000_0000, mtvec value after reset (bits[1:0] forced 0)
MSTATUS_MIE_BIT, 3, bit position of MIE in mstatus
MSTATUS_MPIE_BIT, 7, bit position of MPIE in mstatus

Ports:
clk  input  1  clock
start  input  1  reset, synchronous, active-low (!start = reset)
trap_req_w  input  trap_req_t  {valid, mode TRAP_ENTER/TRAP_RETURN, cause[31:0], pc[31:0], tval[31:0]} at writeback
csr_valid_w  input  1  writeback instruction is a CSR access
csr_addr_w  input  12  CSR address
csr_op_w  input  3  funct3: 1/5 RW, 2/6 RS, 3/7 RC (zimm already in wdata)
csr_wdata_w  input  32  rs1 value or zero-extended zimm
csr_rdata_w  output  32  old CSR value, combinational
kill_w  output  1  suppress regwrite of writeback instruction, combinational
flush_all  output  1  flush F/D/E/M registers, registered
redirect_valid  output  1  fetch must load redirect_pc, registered
redirect_pc  output  32  trap/return target, registered
busy  output  1  state != IDLE

Behaviour:
- One clock (clk). Reset is synchronous and active-low on start: when !start at posedge clk, all state below resets.
- Reset values:
  - state=IDLE, flush_all=0, redirect_valid=0, redirect_pc=0.
  - mstatus, mepc, mcause, mtval and mscratch = 0; mtvec=MTVEC_RESET.
  - Reset has priority over everything, including a trap in flight or a FLUSH state.
- FSM states IDLE, FLUSH.
  - IDLE with trap_req_w.valid: commit at edge N, go to FLUSH.
  - FLUSH: flush_all=1 and redirect_valid=1 for exactly the cycle after edge N; return to IDLE at edge N+1.
  - In FLUSH, trap_req_w and csr_valid_w are ignored, because they come from flushed younger instructions.
- TRAP_ENTER commit:
  - mepc<=pc&~3, mcause<=cause, mtval<=tval.
  - MPIE<=MIE, MIE<=0.
  - redirect_pc<=mtvec&~3 (direct mode only).
- TRAP_RETURN (mret) commit:
  - MIE<=MPIE, MPIE<=1.
  - redirect_pc<=mepc; no other CSR changes.
- kill_w = (state==IDLE) && trap_req_w.valid && mode==TRAP_ENTER. A returning mret writes no register, so it is not killed.
- CSR map: 0x300 mstatus (only MIE/MPIE writable, others read 0), 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval. Any other address reads 0 and ignores writes; illegal addresses are detected in decode.
- CSR read: csr_rdata_w = current value, combinational, valid whenever csr_valid_w.
- CSR write at edge when csr_valid_w && state==IDLE && !trap_req_w.valid:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - RS/RC with wdata==0 perform no write.
  - Writes to mtvec and mepc force bits[1:0]=0.
- Simultaneous CSR access and trap on the same cycle: the trap wins and the CSR write is dropped.
- Back-to-back: a trap on the cycle immediately after FLUSH ends is accepted normally. The minimum spacing between two commits is 2 cycles.

Test Plan:
1. Reset, then read 0x305 -> csr_rdata_w=MTVEC_RESET; read 0x341 -> 0; flush_all=0, busy=0.
2. CSRRW 0x305 wdata=32'h8000_0103, then ENTER cause=2 pc=32'h0000_0104 tval=32'h0000_FFFF:
   - kill_w=1 in the same cycle;
   - next cycle flush_all=1, redirect_valid=1, redirect_pc=32'h8000_0100;
   - mepc=0x104, mcause=2, mtval=0xFFFF, MIE=0.
3. Set MIE via CSRRS 0x300 wdata=0x8, then ENTER, then RETURN:
   - after ENTER: mstatus=0x80;
   - after RETURN: mstatus=0x88, redirect_pc=0x104;
   - kill_w=0 on the RETURN cycle.
4. CSRRC 0x300 wdata=0x8 in the same cycle as an ENTER -> write dropped; MPIE=1, MIE=0.
5. Second trap_req_w.valid asserted during FLUSH -> ignored, mepc unchanged, single flush pulse. A trap presented the next cycle is accepted.
6. Deassert start during FLUSH -> next cycle flush_all=0, redirect_valid=0, all CSRs 0, mtvec=MTVEC_RESET.
